// File: rtl/mmio_buttons_if.sv
// mmio_buttons_if: CPU data-bus signals between the CPU (master) and the button responder (slave)
interface mmio_buttons_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        hit;
  modport master (output memread, memwrite, addr, writedata, input readdata, hit);
  modport slave (input memread, memwrite, addr, writedata, output readdata, hit);
endinterface

// File: rtl/mmio_buttons.sv
// mmio_buttons: debounced buttons with sticky edge flags and a press counter; MMIO_BUTTONS_RELEASE_EN adds release flags in EDGE[7:4]
module mmio_buttons #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0010,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  mmio_buttons_if.slave  bus,
  input  logic [3:0]     btn,
  output logic [3:0]     pressed
);
  localparam logic [23:0] LAST = 24'(DEBOUNCE_CYCLES - 1);
`ifdef MMIO_BUTTONS_RELEASE_EN
  localparam int EW = 8;
`else
  localparam int EW = 4;
`endif
  logic [3:0] sync1, sync2, stable, stable_next, rise;
  logic [23:0] cnt [4];
  logic [23:0] cnt_next [4];
  logic [EW-1:0] flags, set, clr;
  logic [15:0] count, count_next;
  logic [1:0] off;
  logic wr;
  assign bus.hit = bus.addr[31:4] == BASE_ADDR[31:4];
  assign off = bus.addr[3:2];
  assign wr = bus.hit && bus.memwrite;
  assign pressed = stable;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = (sync2[i] == stable[i] || cnt[i] == LAST) ? '0 : cnt[i] + 24'd1;
      stable_next[i] = (sync2[i] != stable[i] && cnt[i] == LAST) ? sync2[i] : stable[i];
    end
  end
  assign rise = stable_next & ~stable;
`ifdef MMIO_BUTTONS_RELEASE_EN
  assign set = {~stable_next & stable, rise};
`else
  assign set = rise;
`endif
  assign clr = (wr && off == 2'd1) ? bus.writedata[EW-1:0] : '0;
  // a COUNT write discards any presses landing in the same cycle
  assign count_next = (wr && off == 2'd2) ? bus.writedata[15:0]
                    : count + 16'(rise[0]) + 16'(rise[1]) + 16'(rise[2]) + 16'(rise[3]);
  assign bus.readdata = !(bus.hit && bus.memread) ? 32'h0
                      : off == 2'd0 ? {28'h0, stable}
                      : off == 2'd1 ? 32'(flags)
                      : off == 2'd2 ? {16'h0, count}
                      : 32'h0;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      flags <= '0;
      count <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      stable <= stable_next;
      flags <= (flags & ~clr) | set;
      count <= count_next;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_next[i];
    end
  end
endmodule

// File: tb/tb_mmio_buttons.sv
// tb_mmio_buttons: vector table plus scoreboarded sequences for mmio_buttons with DEBOUNCE_CYCLES=4
module tb_mmio_buttons;
  logic clk = 0, reset = 1;
  logic [3:0] btn = 0, pressed;
  mmio_buttons_if bus();
  mmio_buttons #(.DEBOUNCE_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus), .btn(btn), .pressed(pressed));
  always #5 clk = ~clk;
`ifdef MMIO_BUTTONS_RELEASE_EN
  localparam bit REL = 1;
`else
  localparam bit REL = 0;
`endif
  int passed = 0, total = 0;
  typedef struct {string name; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  typedef struct {logic [31:0] addr; logic rd; logic hit; logic [31:0] data; string name;} vec_t;
  vec_t vecs[7];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic rd(logic [31:0] a, logic [31:0] e, logic h, string n, logic r = 1);
    exp_t x;
    bus.addr = a;
    bus.memread = r;
    sb.push_back('{n, e});
    #2;
    x = sb.pop_front();
    chk(x.name, bus.readdata, x.exp);
    chk({n, "_hit"}, 32'(bus.hit), 32'(h));
    bus.memread = 0;
  endtask
  task automatic wr(logic [31:0] a, logic [31:0] d);
    bus.addr = a;
    bus.writedata = d;
    bus.memwrite = 1;
    @(posedge clk);
    @(negedge clk);
    bus.memwrite = 0;
  endtask
  initial begin
    exp_t x;
    vecs[0] = '{32'hFFFF_0010, 1, 1, 0, "rst_state"};
    vecs[1] = '{32'hFFFF_0014, 1, 1, 0, "rst_edge"};
    vecs[2] = '{32'hFFFF_0018, 1, 1, 0, "rst_count"};
    vecs[3] = '{32'hFFFF_001C, 1, 1, 0, "rst_resv"};
    vecs[4] = '{32'hFFFF_001B, 1, 1, 0, "rst_lowbits"};
    vecs[5] = '{32'h0000_0018, 1, 0, 0, "rst_outside"};
    vecs[6] = '{32'hFFFF_0010, 0, 1, 0, "rst_noread"};
    bus.memread = 0; bus.memwrite = 0; bus.addr = 0; bus.writedata = 0;
    tick(2);
    reset = 0;
    chk("rst_pressed", 32'(pressed), 0);
    foreach (vecs[k]) begin
      rd(vecs[k].addr, vecs[k].data, vecs[k].hit, vecs[k].name, vecs[k].rd);
      tick();
    end
    // clean press: visible exactly 6 cycles after the change
    btn = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("lat_%0d", k), 32'(pressed[0]), 32'(k == 6));
    end
    rd(32'hFFFF_0014, 32'h1, 1, "edge_b0");
    rd(32'hFFFF_0018, 32'h1, 1, "count_b0");
    rd(32'hFFFF_0010, 32'h1, 1, "state_b0");
    // 3-cycle glitch must be filtered
    btn = 4'b0101; tick(3);
    btn = 4'b0001; tick(10);
    chk("glitch_pressed", 32'(pressed), 32'h1);
    rd(32'hFFFF_0014, 32'h1, 1, "glitch_edge");
    rd(32'hFFFF_0018, 32'h1, 1, "glitch_count");
    btn = 4'b0101; tick(6);
    rd(32'hFFFF_0014, 32'h5, 1, "edge_5");
    btn = 4'b0100; tick(6);
    chk("rel_b0_pressed", 32'(pressed), 32'h4);
    rd(32'hFFFF_0014, 32'h5 | (REL ? 32'h10 : 0), 1, "edge_after_rel");
    // clear of bit0 lands on the same edge as its new rise: set wins
    btn = 4'b0101; tick(5);
    wr(32'hFFFF_0014, 32'h1);
    chk("setwin_pressed", 32'(pressed), 32'h5);
    rd(32'hFFFF_0014, 32'h5 | (REL ? 32'h10 : 0), 1, "set_wins");
    wr(32'hFFFF_0014, 32'h4);
    rd(32'hFFFF_0014, 32'h1 | (REL ? 32'h10 : 0), 1, "w1c_b2");
    rd(32'hFFFF_0018, 32'h3, 1, "count_3");
    wr(32'hFFFF_0018, 32'hFFFF);
    rd(32'hFFFF_0018, 32'hFFFF, 1, "count_load");
    btn = 4'b1111; tick(6);
    rd(32'hFFFF_0018, 32'h1, 1, "count_wrap");
    rd(32'hFFFF_0014, 32'hB | (REL ? 32'h10 : 0), 1, "edge_b13");
    rd(32'h0000_0018, 32'h0, 0, "outside");
    // simultaneous read and write returns the old value
    bus.addr = 32'hFFFF_0018; bus.writedata = 32'h1234; bus.memread = 1; bus.memwrite = 1;
    sb.push_back('{"rw_old", 32'h1});
    #2;
    x = sb.pop_front();
    chk(x.name, bus.readdata, x.exp);
    @(posedge clk); @(negedge clk);
    bus.memread = 0; bus.memwrite = 0;
    rd(32'hFFFF_0018, 32'h1234, 1, "rw_new");
    wr(32'hFFFF_0010, 32'hF0F);
    rd(32'hFFFF_0010, 32'hF, 1, "state_ro");
    wr(32'hFFFF_001C, 32'hFFFF);
    rd(32'hFFFF_001C, 32'h0, 1, "resv_ro");
    // press and release btn[3] from a cleared EDGE
    wr(32'hFFFF_0014, 32'hFF);
    btn = 4'b0111; tick(6);
    wr(32'hFFFF_0014, 32'hFF);
    rd(32'hFFFF_0014, 32'h0, 1, "edge_clr");
    btn = 4'b1111; tick(6);
    btn = 4'b0111; tick(6);
    rd(32'hFFFF_0014, REL ? 32'h88 : 32'h08, 1, "edge_pr_rel");
    wr(32'hFFFF_0014, 32'h80);
    rd(32'hFFFF_0014, 32'h08, 1, "edge_clr80");
    rd(32'hFFFF_0018, 32'h1235, 1, "count_presses");
    // reset mid-debounce, button still held afterwards
    btn = 4'b1111; tick(3);
    reset = 1; tick();
    reset = 0;
    chk("rst2_pressed", 32'(pressed), 0);
    rd(32'hFFFF_0014, 32'h0, 1, "rst2_edge");
    rd(32'hFFFF_0018, 32'h0, 1, "rst2_count");
    tick(5);
    chk("redeb_early", 32'(pressed), 0);
    tick();
    chk("redeb_pressed", 32'(pressed), 32'hF);
    rd(32'hFFFF_0014, 32'hF, 1, "redeb_edge");
    rd(32'hFFFF_0018, 32'h4, 1, "redeb_count");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mmio_buttons.md
Name: mmio_buttons

Overview:
- Memory-mapped button peripheral; the responder on the CPU data bus (memread/memwrite/addr/writedata/readdata) for the four directional buttons.
- Synchronises and debounces each button, latches sticky press edges, and keeps a press counter. The CPU reads these as words.
- Lives beside the hex/switch MMIO responder. Top-level ORs readdata from both responders; this block drives zero when not addressed.

Parameters:
- BASE_ADDR, 32'hFFFF_0010, base of the 16-byte register window; bits [3:0] must be zero.
- DEBOUNCE_CYCLES, 1000000, cycles a synced level must hold before it is accepted (10 ms at 100 MHz); legal range 2..2^24-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- memread  input  1  CPU read strobe.
- memwrite  input  1  CPU write strobe.
- addr  input  32  CPU byte address.
- writedata  input  32  CPU write data.
- readdata  output  32  read data; zero unless hit and memread.
- hit  output  1  addr falls in this block's window.
- btn  input  4  raw buttons {U,L,R,D} = bits {3,2,1,0}, asynchronous.
- pressed  output  4  debounced button levels (for LEDs).

Behaviour:
- Decode: hit = (addr[31:4] == BASE_ADDR[31:4]), combinational. Word offset = addr[3:2]. addr[1:0] is ignored.
- Register map:
  - 0x0 STATE: RO, bits[3:0] = debounced levels; writes ignored.
  - 0x4 EDGE: sticky press flags in bits[3:0]; write-1-to-clear.
  - 0x8 COUNT: 16-bit total press count in bits[15:0]; a write loads writedata[15:0].
  - 0xC: reserved; reads 0, writes ignored.
  - All unused bits read 0.
- readdata is combinational from registered state: selected register when hit && memread, else 32'h0.
- Writes take effect on the clk edge where hit && memwrite.
- memread and memwrite together: read returns the pre-write value; the write still commits.
- Synchroniser: two flops per button, reset to 0.
- Debounce, one counter per button (24 bits):
  - If synced == stable, counter clears to 0.
  - Otherwise counter increments. On the edge where counter == DEBOUNCE_CYCLES-1, stable <= synced and counter <= 0.
  - Net latency: a clean input change appears on pressed exactly DEBOUNCE_CYCLES+2 cycles later.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes stable.
- Press edge: rise[i] = stable_next[i] & ~stable[i], a one-cycle pulse.
- EDGE update per bit: edge <= (edge & ~clr) | rise, where clr = writedata[3:0] on an EDGE write. If a set and a clear hit the same bit in the same cycle, the set wins.
- COUNT update:
  - Increments by popcount(rise), 0..4; wraps modulo 2^16 (0xFFFF + 1 = 0x0000).
  - A COUNT write in the same cycle as rises loads writedata[15:0]; those increments are discarded.
- Reset: sync flops, stable, debounce counters, EDGE and COUNT all clear to 0.
  - pressed = 0 the cycle after reset.
  - readdata = 0 while memread is low. hit stays combinational.
  - Reset mid-debounce discards the partial count. A button still held after reset re-debounces and produces a fresh press edge.

Optional Feature:
- Macro: MMIO_BUTTONS_RELEASE_EN.
- Defined:
  - EDGE bits[7:4] hold sticky release flags (fall = ~stable_next & stable), same W1C and set-wins rules, cleared by writedata[7:4].
  - COUNT still counts presses only.
- Undefined: EDGE bits[7:4] read 0, no release logic is built, and writes to bits[7:4] have no effect.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, idle bus, read 0xFFFF0010/14/18/1C -> readdata 0 each; hit=1; pressed=0.
- Hold btn=4'b0001 steady -> pressed[0] rises exactly 6 cycles after the change; EDGE reads 0x1; COUNT reads 0x0001.
- Pulse btn[2] high for 3 cycles, then low -> pressed, EDGE and COUNT unchanged.
- EDGE=0x5, write 0x1 to 0xFFFF0014 in the same cycle as btn[0] debounces high again -> EDGE reads 0x5 (set wins). Next, write 0x4 -> EDGE reads 0x1.
- Write 0xFFFF to COUNT, then debounce btn[1] and btn[3] in the same cycle -> COUNT = 0x0001 (wrap, +2). Read at 0x00000018 (outside window) -> hit=0, readdata 0.
- With MMIO_BUTTONS_RELEASE_EN: press and release btn[3] -> EDGE = 0x88. Write 0x80 -> EDGE = 0x08. Without the macro, the same sequence -> EDGE = 0x08.
